// File: rtl/v4_filter_sequencer_pkg.sv
// Shared widths, sequencer state type, event record and saturating-add helper
// for the v4 filter run-control sequencer.
package v4_parameters;

  localparam int SIZE_FILTER_DATA = 16;
  localparam int TS_WIDTH         = 32;
  localparam int DROP_WIDTH       = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ARMED,
    WAIT_PEAK,
    OUTPUT,
    HOLDOFF,
    WAIT_LOW
  } seq_state_t;

  typedef struct packed {
    logic [SIZE_FILTER_DATA-1:0] amplitude;
    logic [TS_WIDTH-1:0]         timestamp;
  } ev_t;

  // Lost-event counter pins at all-ones instead of wrapping back to a small value.
  function automatic logic [DROP_WIDTH-1:0] sat_add(input logic [DROP_WIDTH-1:0] base,
                                                    input logic [1:0]            inc);
    logic [DROP_WIDTH:0] sum;
    sum = {1'b0, base} + {{(DROP_WIDTH - 1){1'b0}}, inc};
    return sum[DROP_WIDTH] ? '1 : sum[DROP_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/v4_filter_sequencer_if.sv
// Event hand-off from the sequencer to the channel readout FIFO (valid/ready).
interface v4_filter_sequencer_if;
  import v4_parameters::*;

  logic                        ev_valid;
  logic                        ev_ready;
  logic [SIZE_FILTER_DATA-1:0] ev_amplitude;
  logic [TS_WIDTH-1:0]         ev_timestamp;

  modport master (output ev_valid, output ev_amplitude, output ev_timestamp, input ev_ready);
  modport slave  (input ev_valid, input ev_amplitude, input ev_timestamp, output ev_ready);

endinterface

// File: rtl/v4_filter_sequencer_seq_counter.sv
// Loadable down-counter with a zero flag; a phase loaded with N-1 ends on the
// cycle done is seen, so the phase lasts exactly N cycles.
module v4_seq_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/v4_filter_sequencer.sv
// Run-control and event capture for one trapezoidal filter channel: release the
// filter, settle, arm, trigger on threshold, sample flat-top, hand event to readout.
module v4_filter_sequencer
  import v4_parameters::*;
#(
  parameter int SETTLE_CYC  = 64,
  parameter int PEAK_DELAY  = 12,
  parameter int HOLDOFF_CYC = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [SIZE_FILTER_DATA-1:0] threshold,
  input  logic [SIZE_FILTER_DATA-1:0] filter_data,
  output logic                        filter_rst_n,
  output logic                        armed,
  output logic [DROP_WIDTH-1:0]       drop_cnt,
  v4_filter_sequencer_if.master       ev
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] PEAK_LOAD   = CNT_W'((PEAK_DELAY > 0) ? PEAK_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLDOFF_CYC - 1);

  seq_state_t                  state_q, state_d;
  logic [TS_WIDTH-1:0]         ts_q, ts_d;
  ev_t                         ev_q, ev_d;
  logic                        valid_q, valid_d;
  logic [DROP_WIDTH-1:0]       drop_q, drop_d;
  logic [SIZE_FILTER_DATA-1:0] prev_q, prev_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_done;
  logic             out_rise;
  logic             lost;

  v4_seq_counter #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    ev_d     = ev_q;
    valid_d  = valid_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    lost     = 1'b0;
    prev_d   = filter_data;
    ts_d     = (state_q == IDLE) ? '0 : ts_q + TS_WIDTH'(1);
    out_rise = (state_q == OUTPUT) && (prev_q <= threshold) && (filter_data > threshold);

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = SETTLE;
          cnt_load = 1'b1;
          cnt_val  = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (cnt_done) state_d = ARMED;
      end
      ARMED: begin
        if (filter_data > threshold) begin
          ev_d.timestamp = ts_q;
          if (PEAK_DELAY == 0) begin
            ev_d.amplitude = filter_data;
            valid_d        = 1'b1;
            state_d        = OUTPUT;
          end else begin
            cnt_load = 1'b1;
            cnt_val  = PEAK_LOAD;
            state_d  = WAIT_PEAK;
          end
        end
      end
      WAIT_PEAK: begin
        if (cnt_done) begin
          ev_d.amplitude = filter_data;
          valid_d        = 1'b1;
          state_d        = OUTPUT;
        end
      end
      OUTPUT: begin
        if (ev.ev_ready) begin
          valid_d  = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = HOLD_LOAD;
          state_d  = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (cnt_done) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (filter_data <= threshold) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase

    // Disable wins over everything; an unaccepted pending event is counted as lost.
    if (!enable) begin
      lost    = valid_q && !ev.ev_ready;
      valid_d = 1'b0;
      state_d = IDLE;
    end

    drop_d = sat_add(drop_q, {1'b0, out_rise} + {1'b0, lost});
  end

  // NOTE: flops use non-blocking <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ts_q    <= '0;
      ev_q    <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      ev_q    <= ev_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      prev_q  <= prev_d;
    end
  end

  assign filter_rst_n    = (state_q != IDLE);
  assign armed           = (state_q == ARMED);
  assign drop_cnt        = drop_q;
  assign ev.ev_valid     = valid_q;
  assign ev.ev_amplitude = ev_q.amplitude;
  assign ev.ev_timestamp = ev_q.timestamp;

endmodule

// File: tb/tb_v4_filter_sequencer.sv
// Self-checking bench: two sequencers (flat-top delay 12 and 0) share stimulus and are
// compared every cycle against a timestamp-driven behavioural model, plus literal checkpoints.
module tb_v4_filter_sequencer;

  localparam int DW     = v4_parameters::SIZE_FILTER_DATA;
  localparam int TW     = v4_parameters::TS_WIDTH;
  localparam int SETTLE = 64;
  localparam int HOLD   = 32;

  localparam int P_OFF = 0, P_WARMUP = 1, P_READY = 2, P_PEAK = 3,
                 P_PENDING = 4, P_DEAD = 5, P_LOW = 6;

  typedef struct {
    int            phase;
    logic [TW-1:0] ts;
    logic [TW-1:0] mark;
    logic          valid;
    logic [DW-1:0] amp;
    logic [TW-1:0] tsout;
    logic [DW-1:0] prev;
    int            drop;
  } mdl_t;

  logic          clk = 1'b0;
  logic          reset, enable, ev_ready;
  logic [DW-1:0] threshold, filter_data;
  logic          frn, frn0, armed, armed0;
  logic [15:0]   drop, drop0;
  logic          chk_on = 1'b0;
  int            n_vec  = 0;
  int            n_miss = 0;
  mdl_t          m12, m0;

  always #5 clk = ~clk;

  v4_filter_sequencer_if ev_if ();
  v4_filter_sequencer_if ev0_if ();
  assign ev_if.ev_ready  = ev_ready;
  assign ev0_if.ev_ready = ev_ready;

  v4_filter_sequencer #(.SETTLE_CYC(SETTLE), .PEAK_DELAY(12), .HOLDOFF_CYC(HOLD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .threshold(threshold), .filter_data(filter_data),
    .filter_rst_n(frn), .armed(armed), .drop_cnt(drop), .ev(ev_if));

  v4_filter_sequencer #(.SETTLE_CYC(SETTLE), .PEAK_DELAY(0), .HOLDOFF_CYC(HOLD)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .threshold(threshold), .filter_data(filter_data),
    .filter_rst_n(frn0), .armed(armed0), .drop_cnt(drop0), .ev(ev0_if));

  // Next model state from the rules: phases end at absolute timestamps, not via counters.
  function automatic mdl_t mdl_next(input mdl_t m, input int pd, input logic rst_n,
                                    input logic en, input logic rdy,
                                    input logic [DW-1:0] thr, input logic [DW-1:0] d);
    mdl_t n;
    int   lost;
    n = m;
    if (!rst_n) begin
      n.phase = P_OFF; n.ts = '0; n.mark = '0; n.valid = 1'b0;
      n.amp = '0; n.tsout = '0; n.prev = '0; n.drop = 0;
      return n;
    end
    lost   = 0;
    n.ts   = (m.phase == P_OFF) ? '0 : m.ts + TW'(1);
    n.prev = d;
    if (m.phase == P_PENDING && m.prev <= thr && d > thr) lost++;
    if (!en) begin
      if (m.valid && !rdy) lost++;
      n.valid = 1'b0;
      n.phase = P_OFF;
    end else begin
      case (m.phase)
        P_OFF:    n.phase = P_WARMUP;
        P_WARMUP: if (m.ts == TW'(SETTLE - 1)) n.phase = P_READY;
        P_READY: if (d > thr) begin
          n.tsout = m.ts;
          n.mark  = m.ts + TW'(pd);
          if (pd == 0) begin
            n.amp = d; n.valid = 1'b1; n.phase = P_PENDING;
          end else begin
            n.phase = P_PEAK;
          end
        end
        P_PEAK: if (m.ts == m.mark) begin
          n.amp = d; n.valid = 1'b1; n.phase = P_PENDING;
        end
        P_PENDING: if (rdy) begin
          n.valid = 1'b0; n.mark = m.ts + TW'(HOLD); n.phase = P_DEAD;
        end
        P_DEAD:  if (m.ts == m.mark) n.phase = P_LOW;
        P_LOW:   if (d <= thr) n.phase = P_READY;
        default: n.phase = P_OFF;
      endcase
    end
    n.drop = (m.drop + lost > 65535) ? 65535 : m.drop + lost;
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    m12 = mdl_next(m12, 12, reset, enable, ev_ready, threshold, filter_data);
    m0  = mdl_next(m0, 0, reset, enable, ev_ready, threshold, filter_data);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("pd12 rstn/armed/valid", 64'({frn, armed, ev_if.ev_valid}),
            64'({m12.phase != P_OFF, m12.phase == P_READY, m12.valid}));
      check("pd12 drop_cnt", 64'(drop), 64'(m12.drop));
      check("pd12 amplitude", 64'(ev_if.ev_amplitude), 64'(m12.amp));
      check("pd12 timestamp", 64'(ev_if.ev_timestamp), 64'(m12.tsout));
      check("pd0 rstn/armed/valid", 64'({frn0, armed0, ev0_if.ev_valid}),
            64'({m0.phase != P_OFF, m0.phase == P_READY, m0.valid}));
      check("pd0 drop_cnt", 64'(drop0), 64'(m0.drop));
      check("pd0 amplitude", 64'(ev0_if.ev_amplitude), 64'(m0.amp));
      check("pd0 timestamp", 64'(ev0_if.ev_timestamp), 64'(m0.tsout));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; ev_ready = 1'b0; threshold = DW'(100); filter_data = DW'(50);
    cyc(3);
    chk_on = 1'b1;
    check("reset outputs", 64'({frn, armed, ev_if.ev_valid, drop, ev_if.ev_amplitude}), 64'(0));
    check("reset timestamp", 64'(ev_if.ev_timestamp), 64'(0));

    // Release and settle: filter out of reset one cycle later, armed 64 cycles after that.
    reset = 1'b1; enable = 1'b1;
    cyc(1);
    check("release filter_rst_n", 64'(frn), 64'(1));
    cyc(63);
    check("armed early", 64'(armed), 64'(0));
    cyc(1);
    check("armed at 64", 64'(armed), 64'(1));

    // Step through threshold at ts=80, ramp so the flat-top sample is identifiable.
    cyc(16);
    for (int k = 0; k <= 12; k++) begin
      filter_data = DW'(200 + k);
      if (k == 12) check("valid before n+13", 64'(ev_if.ev_valid), 64'(0));
      cyc(1);
    end
    check("event valid at 93", 64'(ev_if.ev_valid), 64'(1));
    check("event timestamp 80", 64'(ev_if.ev_timestamp), 64'(80));
    check("event amplitude ts92", 64'(ev_if.ev_amplitude), 64'(212));
    check("pd0 amplitude at crossing", 64'(ev0_if.ev_amplitude), 64'(200));
    check("pd0 timestamp 80", 64'(ev0_if.ev_timestamp), 64'(80));

    // Readout stalls 40 cycles while three rising crossings happen.
    for (int i = 0; i < 40; i++) begin
      filter_data = (i == 5 || i == 15 || i == 25) ? DW'(50) : DW'(212);
      cyc(1);
    end
    check("stall drop_cnt", 64'(drop), 64'(3));
    check("stall held valid", 64'(ev_if.ev_valid), 64'(1));
    check("stall held amplitude", 64'(ev_if.ev_amplitude), 64'(212));
    ev_ready = 1'b1; filter_data = DW'(200);
    cyc(1);
    ev_ready = 1'b0;
    check("valid drops after accept", 64'(ev_if.ev_valid), 64'(0));

    // Data stays high through holdoff: no re-arm until it falls to threshold.
    cyc(50);
    check("no re-arm while high", 64'(armed), 64'(0));
    filter_data = DW'(90);
    cyc(1);
    check("re-arm after low", 64'(armed), 64'(1));

    // Disable with an unaccepted event pending.
    filter_data = DW'(150);
    cyc(13);
    check("second event valid", 64'(ev_if.ev_valid), 64'(1));
    enable = 1'b0;
    cyc(1);
    check("disable drops event", 64'({frn, ev_if.ev_valid, drop}), 64'({2'b00, 16'd4}));

    // Disable in the same cycle as accept: handshake completes, nothing lost.
    enable = 1'b1; filter_data = DW'(50);
    cyc(65);
    check("re-armed after enable", 64'(armed), 64'(1));
    filter_data = DW'(150);
    cyc(13);
    ev_ready = 1'b1; enable = 1'b0;
    cyc(1);
    ev_ready = 1'b0;
    check("accept+disable no drop", 64'({frn, ev_if.ev_valid, drop}), 64'({2'b00, 16'd4}));

    // Randomised run: data wanders around threshold, stalls, disables and rare resets.
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 399) == 0) ? 1'b0 : (enable | ($urandom_range(0, 3) == 0));
      reset  = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 9) < 3) filter_data = DW'($urandom_range(0, 200));
      if ($urandom_range(0, 499) == 0) threshold = DW'($urandom_range(50, 150));
      ev_ready = ($urandom_range(0, 3) == 0);
      cyc(1);
    end

    // Reset asserted while waiting for the flat-top sample.
    reset = 1'b1; enable = 1'b0; ev_ready = 1'b0; threshold = DW'(100); filter_data = DW'(50);
    cyc(2);
    enable = 1'b1;
    cyc(71);
    filter_data = DW'(150);
    cyc(5);
    reset = 1'b0;
    cyc(1);
    check("reset in wait_peak", 64'({frn, armed, ev_if.ev_valid, drop, ev_if.ev_amplitude}), 64'(0));
    check("reset in wait_peak ts", 64'(ev_if.ev_timestamp), 64'(0));
    reset = 1'b1; filter_data = DW'(50);

    // Drive one rising crossing per cycle while stalled to saturate drop_cnt.
    cyc(70);
    filter_data = DW'(150);
    cyc(13);
    filter_data = DW'(0); threshold = DW'(0);
    cyc(1);
    for (int d = 1; d <= 65534; d++) begin
      filter_data = DW'(d); threshold = DW'(d - 1);
      cyc(1);
    end
    check("drop before saturation", 64'(drop), 64'(16'hFFFE));
    filter_data = DW'(65535); threshold = DW'(65534);
    cyc(1);
    check("drop reaches max", 64'(drop), 64'(16'hFFFF));
    filter_data = DW'(0); threshold = DW'(0);
    cyc(1);
    for (int d = 1; d <= 4; d++) begin
      filter_data = DW'(d); threshold = DW'(d - 1);
      cyc(1);
    end
    check("drop saturated", 64'(drop), 64'(16'hFFFF));
    enable = 1'b0;
    cyc(1);
    check("drop saturated on disable", 64'({ev_if.ev_valid, drop}), 64'({1'b0, 16'hFFFF}));
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
